// File: rtl/usart_pkg.sv
// Shared constants and state encoding for the USART LED command parser.
package usart_pkg;

   localparam logic [7:0] CH_L     = 8'h4C;
   localparam logic [7:0] CH_C     = 8'h43;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_1     = 8'h31;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] ACK_CHAR = 8'h4B;
   localparam logic [7:0] NAK_CHAR = 8'h45;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_GET_IDX = 3'd1;
   localparam logic [2:0] ST_GET_VAL = 3'd2;
   localparam logic [2:0] ST_GET_END = 3'd3;
   localparam logic [2:0] ST_RESPOND = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      GET_IDX = ST_GET_IDX,
      GET_VAL = ST_GET_VAL,
      GET_END = ST_GET_END,
      RESPOND = ST_RESPOND,
      WAIT_TX = ST_WAIT_TX
   } state_e;

   typedef enum logic [1:0] {R_ACK, R_NAK, R_CNT} resp_e;

endpackage

// File: rtl/usart_cmd_parser_gap_timer.sv
// Saturating inter-byte gap timer; expired holds once TIMEOUT_CYCLES-1 is reached.
module usart_gap_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 cnt <= '0;
      else if (clear)             cnt <= '0;
      else if (enable && !expired) cnt <= cnt + CW'(1);
   end

   assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/usart_cmd_parser.sv
// ASCII LED command parser: "L<i><v>\r" sets leds[i], answers ACK/NAK via the tx handshake.
// Optional USART_CMD_ERRCNT_EN adds err_count and the 'C' (read-and-clear) command.
module usart_cmd_parser #(
   parameter int unsigned LED_COUNT      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter logic [7:0]  ACK_CHAR       = 8'h4B,
   parameter logic [7:0]  NAK_CHAR       = 8'h45
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 rx_err,
   input  logic                 tx_busy,
`ifdef USART_CMD_ERRCNT_EN
   output logic [7:0]           err_count,
`endif
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   output logic [LED_COUNT-1:0] leds,
   output logic                 cmd_ok
);

   import usart_pkg::*;

   localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

   state_e               state, state_nxt;
   resp_e                resp, resp_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic                 val, val_nxt;
   logic [LED_COUNT-1:0] leds_nxt;
   logic [7:0]           tx_data_nxt;
   logic                 tx_start_nxt, cmd_ok_nxt;
   logic                 seen_busy, seen_nxt;
   logic                 in_frame, expired;
   logic [7:0]           rx_off;
   logic                 idx_ok;

   assign rx_off   = rx_data - CH_0;
   assign idx_ok   = (rx_data >= CH_0) && (rx_off < 8'(LED_COUNT));
   assign in_frame = (state == GET_IDX) || (state == GET_VAL) || (state == GET_END);

   // One timer covers both the inter-byte gap and the lost-transmitter guard.
   usart_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
      .clock   (clock),
      .reset   (reset),
      .clear   (rx_valid || (state_nxt != state)),
      .enable  (in_frame || ((state == WAIT_TX) && !seen_busy)),
      .expired (expired)
   );

   always_comb begin
      state_nxt    = state;
      resp_nxt     = resp;
      idx_nxt      = idx;
      val_nxt      = val;
      leds_nxt     = leds;
      tx_data_nxt  = tx_data;
      tx_start_nxt = 1'b0;
      cmd_ok_nxt   = 1'b0;
      seen_nxt     = seen_busy;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == CH_L) state_nxt = GET_IDX;
`ifdef USART_CMD_ERRCNT_EN
               else if (rx_data == CH_C) begin
                  resp_nxt  = R_CNT;
                  state_nxt = RESPOND;
               end
`endif
            end
         end
         GET_IDX, GET_VAL, GET_END: begin
            // rx_err wins over a coincident rx_valid; any unexpected byte is a NAK
            if (rx_err) begin
               resp_nxt  = R_NAK;
               state_nxt = RESPOND;
            end else if (rx_valid) begin
               resp_nxt  = R_NAK;
               state_nxt = RESPOND;
               if (state == GET_IDX && idx_ok) begin
                  idx_nxt   = rx_off[IDX_W-1:0];
                  state_nxt = GET_VAL;
               end else if (state == GET_VAL && (rx_data == CH_0 || rx_data == CH_1)) begin
                  val_nxt   = rx_data[0];
                  state_nxt = GET_END;
               end else if (state == GET_END && rx_data == CH_CR) begin
                  leds_nxt[idx] = val;
                  cmd_ok_nxt    = 1'b1;
                  resp_nxt      = R_ACK;
               end
            end else if (expired) begin
               state_nxt = IDLE;
            end
         end
         RESPOND: begin
            if (!tx_busy) begin
               tx_start_nxt = 1'b1;
               seen_nxt     = 1'b0;
               state_nxt    = WAIT_TX;
               tx_data_nxt  = (resp == R_NAK) ? NAK_CHAR : ACK_CHAR;
`ifdef USART_CMD_ERRCNT_EN
               if (resp == R_CNT) tx_data_nxt = err_count;
`endif
            end
         end
         WAIT_TX: begin
            if (tx_busy) seen_nxt = 1'b1;
            if (seen_busy && !tx_busy)      state_nxt = IDLE;
            else if (!seen_busy && expired) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         resp      <= R_ACK;
         idx       <= '0;
         val       <= 1'b0;
         leds      <= '0;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         cmd_ok    <= 1'b0;
         seen_busy <= 1'b0;
      end else begin
         state     <= state_nxt;
         resp      <= resp_nxt;
         idx       <= idx_nxt;
         val       <= val_nxt;
         leds      <= leds_nxt;
         tx_data   <= tx_data_nxt;
         tx_start  <= tx_start_nxt;
         cmd_ok    <= cmd_ok_nxt;
         seen_busy <= seen_nxt;
      end
   end

`ifdef USART_CMD_ERRCNT_EN
   logic err_inc, err_clr;

   // Leaving a frame state toward a NAK or back to IDLE means an error or a gap timeout.
   assign err_inc = in_frame && (((state_nxt == RESPOND) && (resp_nxt == R_NAK)) ||
                                 (state_nxt == IDLE));
   assign err_clr = (state == RESPOND) && !tx_busy && (resp == R_CNT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                            err_count <= 8'h00;
      else if (err_clr)                      err_count <= 8'h00;
      else if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'h01;
   end
`endif

endmodule

// File: tb/tb_usart_cmd_parser.sv
// Directed self-checking bench for usart_cmd_parser with a 20-cycle transmitter busy model.
module tb_usart_cmd_parser;
   import usart_pkg::*;

   localparam int TO = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] leds;
   logic       cmd_ok;
`ifdef USART_CMD_ERRCNT_EN
   logic [7:0] err_count;
`endif

   logic       busy_hold = 1'b0;
   int         busy_cnt = 0;
   int         ntx = 0;
   int         ncmd = 0;
   logic [7:0] last_tx = 8'h00;
   int         checks = 0;
   int         errors = 0;

   usart_cmd_parser #(.LED_COUNT(8), .TIMEOUT_CYCLES(TO)) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .tx_busy  (tx_busy),
`ifdef USART_CMD_ERRCNT_EN
      .err_count(err_count),
`endif
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .leds     (leds),
      .cmd_ok   (cmd_ok)
   );

   always #5 clock = ~clock;

   assign tx_busy = busy_hold || (busy_cnt != 0);

   always @(posedge clock or negedge reset) begin
      if (!reset)             busy_cnt <= 0;
      else if (tx_start)      busy_cnt <= 20;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clock) begin
      if (tx_start) begin
         ntx     <= ntx + 1;
         last_tx <= tx_data;
      end
      if (cmd_ok) ncmd <= ncmd + 1;
   end

   task automatic send(input logic [7:0] b, input logic e, input int gap);
      @(negedge clock);
      rx_data = b; rx_valid = 1'b1; rx_err = e;
      @(negedge clock);
      rx_valid = 1'b0; rx_err = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks += 5;
      if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds: got %h exp 00", leds); end
      if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b exp 0", tx_start); end
      if (cmd_ok !== 1'b0) begin errors++; $display("FAIL rst_cmd_ok: got %b exp 0", cmd_ok); end
      if (dut.state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp 0", dut.state); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_valid_frame();
      int n0, c0;
      n0 = ntx; c0 = ncmd;
      send(CH_L, 1'b0, 10);
      send(8'h33, 1'b0, 10);
      send(CH_1, 1'b0, 10);
      @(negedge clock);
      rx_data = CH_CR; rx_valid = 1'b1;
      checks++;
      if (leds !== 8'h00) begin errors++; $display("FAIL vf_leds_before_cr: got %h exp 00", leds); end
      @(negedge clock);
      rx_valid = 1'b0;
      checks += 2;
      if (leds !== 8'h08) begin errors++; $display("FAIL vf_leds_after_cr: got %h exp 08", leds); end
      if (cmd_ok !== 1'b1) begin errors++; $display("FAIL vf_cmd_ok: got %b exp 1", cmd_ok); end
      repeat (40) @(negedge clock);
      checks += 3;
      if (ntx !== n0 + 1) begin errors++; $display("FAIL vf_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h4B) begin errors++; $display("FAIL vf_tx_data: got %h exp 4b", last_tx); end
      if (ncmd !== c0 + 1) begin errors++; $display("FAIL vf_cmd_ok_count: got %0d exp %0d", ncmd, c0 + 1); end
   endtask

   task automatic test_clear_and_bad_idx();
      int n0, c0;
      n0 = ntx;
      send(CH_L, 1'b0, 10); send(8'h33, 1'b0, 10); send(CH_0, 1'b0, 10); send(CH_CR, 1'b0, 40);
      checks += 3;
      if (leds !== 8'h00) begin errors++; $display("FAIL clr_leds: got %h exp 00", leds); end
      if (ntx !== n0 + 1) begin errors++; $display("FAIL clr_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h4B) begin errors++; $display("FAIL clr_tx_data: got %h exp 4b", last_tx); end
      n0 = ntx; c0 = ncmd;
      send(CH_L, 1'b0, 10); send(8'h39, 1'b0, 10); send(CH_1, 1'b0, 10); send(CH_CR, 1'b0, 40);
      checks += 4;
      if (ntx !== n0 + 1) begin errors++; $display("FAIL bad_idx_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h45) begin errors++; $display("FAIL bad_idx_tx_data: got %h exp 45", last_tx); end
      if (leds !== 8'h00) begin errors++; $display("FAIL bad_idx_leds: got %h exp 00", leds); end
      if (ncmd !== c0) begin errors++; $display("FAIL bad_idx_cmd_ok: got %0d exp %0d", ncmd, c0); end
   endtask

   task automatic test_timeout();
      int n0;
      n0 = ntx;
      send(CH_L, 1'b0, 5);
      send(8'h32, 1'b0, 0);
      repeat (99) @(negedge clock);
      checks++;
      if (dut.state !== ST_GET_VAL) begin errors++; $display("FAIL to_state_99: got %0d exp 2", dut.state); end
      @(negedge clock);
      checks += 3;
      if (dut.state !== ST_IDLE) begin errors++; $display("FAIL to_state_100: got %0d exp 0", dut.state); end
      if (ntx !== n0) begin errors++; $display("FAIL to_no_tx: got %0d exp %0d", ntx, n0); end
      if (leds !== 8'h00) begin errors++; $display("FAIL to_leds: got %h exp 00", leds); end
      send(CH_L, 1'b0, 10); send(8'h32, 1'b0, 10); send(CH_1, 1'b0, 10); send(CH_CR, 1'b0, 40);
      checks += 3;
      if (leds !== 8'h04) begin errors++; $display("FAIL to_retry_leds: got %h exp 04", leds); end
      if (ntx !== n0 + 1) begin errors++; $display("FAIL to_retry_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h4B) begin errors++; $display("FAIL to_retry_tx_data: got %h exp 4b", last_tx); end
   endtask

   task automatic test_busy_hold();
      int n0;
      n0 = ntx;
      busy_hold = 1'b1;
      send(CH_L, 1'b0, 5); send(8'h35, 1'b0, 5); send(CH_1, 1'b0, 5); send(CH_CR, 1'b0, 50);
      checks += 2;
      if (ntx !== n0) begin errors++; $display("FAIL busy_no_tx: got %0d exp %0d", ntx, n0); end
      if (leds !== 8'h24) begin errors++; $display("FAIL busy_leds: got %h exp 24", leds); end
      busy_hold = 1'b0;
      repeat (5) @(negedge clock);
      checks += 2;
      if (ntx !== n0 + 1) begin errors++; $display("FAIL busy_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h4B) begin errors++; $display("FAIL busy_tx_data: got %h exp 4b", last_tx); end
      repeat (30) @(negedge clock);
   endtask

   task automatic test_rx_err();
      int n0, c0;
      n0 = ntx; c0 = ncmd;
      send(CH_L, 1'b0, 5); send(8'h34, 1'b0, 5); send(CH_1, 1'b1, 30);
      checks += 4;
      if (ntx !== n0 + 1) begin errors++; $display("FAIL err_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h45) begin errors++; $display("FAIL err_tx_data: got %h exp 45", last_tx); end
      if (leds !== 8'h24) begin errors++; $display("FAIL err_leds: got %h exp 24", leds); end
      if (ncmd !== c0) begin errors++; $display("FAIL err_cmd_ok: got %0d exp %0d", ncmd, c0); end
   endtask

   task automatic test_mid_reset();
      send(CH_L, 1'b0, 3); send(8'h36, 1'b0, 3);
      checks++;
      if (dut.state !== ST_GET_VAL) begin errors++; $display("FAIL mr_state_pre: got %0d exp 2", dut.state); end
      reset = 1'b0;
      #1;
      checks += 3;
      if (leds !== 8'h00) begin errors++; $display("FAIL mr_leds: got %h exp 00", leds); end
      if (dut.state !== ST_IDLE) begin errors++; $display("FAIL mr_state: got %0d exp 0", dut.state); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL mr_tx_start: got %b exp 0", tx_start); end
      #2;
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_cmd_c();
      int n0;
`ifdef USART_CMD_ERRCNT_EN
      send(CH_L, 1'b0, 3); send(8'h38, 1'b0, 30);
      send(CH_L, 1'b0, 3); send(8'h38, 1'b0, 30);
      checks++;
      if (err_count !== 8'h02) begin errors++; $display("FAIL ec_count: got %h exp 02", err_count); end
      n0 = ntx;
      send(CH_C, 1'b0, 30);
      checks += 3;
      if (ntx !== n0 + 1) begin errors++; $display("FAIL ec_tx_count: got %0d exp %0d", ntx, n0 + 1); end
      if (last_tx !== 8'h02) begin errors++; $display("FAIL ec_tx_data: got %h exp 02", last_tx); end
      if (err_count !== 8'h00) begin errors++; $display("FAIL ec_cleared: got %h exp 00", err_count); end
      send(CH_C, 1'b0, 30);
      checks++;
      if (last_tx !== 8'h00) begin errors++; $display("FAIL ec_tx_data2: got %h exp 00", last_tx); end
`else
      n0 = ntx;
      send(CH_C, 1'b0, 30);
      checks++;
      if (ntx !== n0) begin errors++; $display("FAIL c_ignored: got %0d exp %0d", ntx, n0); end
`endif
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_clear_and_bad_idx();
      test_timeout();
      test_busy_hold();
      test_rx_err();
      test_mid_reset();
      test_cmd_c();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usart_cmd_parser.md
Name: usart_cmd_parser

Overview:
- Downstream consumer of usart_rx inside the USART test design.
- Takes received bytes and parses fixed-format ASCII LED commands.
- Updates an LED register and returns a one-byte acknowledge through the transmitter start/busy handshake.
- Sits between usart_rx (byte source) and the transmitter (my_usart) on the board-level tester.

Parameters:
- LED_COUNT, 8: width of the LED register; command index range is 0..LED_COUNT-1, maximum 8.
- TIMEOUT_CYCLES, 50_000_000: maximum clock cycles allowed between bytes of one frame before it is abandoned.
- ACK_CHAR, 8'h4B: acknowledge byte, 'K'.
- NAK_CHAR, 8'h45: error byte, 'E'.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from usart_rx.
- rx_err  in  1  one-cycle framing-error strobe from usart_rx; coincides with rx_valid or stands alone.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle request to the transmitter.
- tx_busy  in  1  transmitter busy; goes high the cycle after an accepted tx_start.
- leds  out  LED_COUNT  LED register.
- cmd_ok  out  1  one-cycle pulse when a valid frame is applied.

Behaviour:
- Reset values (reset=0, async): state IDLE, leds=0, tx_data=0, tx_start=0, cmd_ok=0, timeout counter=0.
- Frame format: 'L' (0x4C), index '0'..'7' (0x30+i), value '0' or '1', then 0x0D.
- FSM states: IDLE, GET_IDX, GET_VAL, GET_END, RESPOND, WAIT_TX.
- IDLE:
  - rx_valid with 'L' -> GET_IDX.
  - Any other byte is ignored silently and FSM stays in IDLE.
- GET_IDX:
  - Digit with i < LED_COUNT: latch i -> GET_VAL.
  - Anything else: set nak -> RESPOND.
- GET_VAL:
  - '0' or '1': latch value -> GET_END.
  - Anything else: nak -> RESPOND.
- GET_END:
  - 0x0D: update leds[i] and pulse cmd_ok in the same edge -> RESPOND with ack.
  - Else: nak -> RESPOND.
- Timing of a valid frame: leds change on the clock edge that samples the terminator's rx_valid, so 1 cycle latency.
- RESPOND:
  - When tx_busy=0: drive tx_data = ACK_CHAR or NAK_CHAR, pulse tx_start for 1 cycle -> WAIT_TX.
  - If tx_busy=1: hold in RESPOND, with tx_start=0.
- WAIT_TX:
  - Wait for tx_busy to go 1 and then 0, then -> IDLE.
  - If tx_busy never rises within TIMEOUT_CYCLES -> IDLE (lost transmitter guard).
- Bytes arriving in RESPOND or WAIT_TX are dropped; the FSM never queues them.
- rx_err in GET_IDX, GET_VAL or GET_END: nak -> RESPOND. rx_err has priority over a coincident rx_valid.
- rx_err in IDLE is ignored.
- Timeout counter:
  - Cleared on every rx_valid.
  - Counts in GET_IDX, GET_VAL and GET_END.
  - Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE with no response and leds unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1, and it saturates rather than wraps.
- Second 'L' in mid-frame: treated as a bad byte (nak), not a restart.
- Reset asserted mid-frame or mid-response: immediate IDLE, leds cleared, tx_start deasserted. The transmitter may still complete a byte already started.

Optional Feature:
- Macro: USART_CMD_ERRCNT_EN.
- When defined:
  - Adds output port err_count [7:0].
  - Increments on every NAK issued and every frame timeout.
  - Saturates at 8'hFF and resets to 0.
  - Adds command 'C' in IDLE: responds with the err_count value as the tx byte instead of ACK, then clears err_count on the tx_start edge.
- When undefined:
  - No port or counter exists.
  - 'C' is ignored like any non-'L' byte.

Decomposition:
- Shared package usart_pkg holds:
  - ASCII constants: CH_L=8'h4C, CH_C=8'h43, CH_0=8'h30, CH_1=8'h31, CH_CR=8'h0D, ACK_CHAR, NAK_CHAR.
  - The parser state encoding: 3-bit localparams.
- One natural sub-module: usart_gap_timer.
  - Contains the timeout counter.
  - Inputs: clear, enable. Output: expired.
  - Reused by WAIT_TX and frame states.
- Everything else stays in one FSM body.

Test Plan:
- Bytes 'L','3','1',0x0D with 10-cycle gaps, tx_busy model 20 cycles -> leds=8'h08 one cycle after the 0x0D strobe; cmd_ok pulses once; one tx_start with tx_data=8'h4B.
- After the above, 'L','3','0',0x0D -> leds=8'h00 and ACK sent; then 'L','9','1',0x0D -> one tx_start with 8'h45 on the '9' byte; the remaining '1' and 0x0D are consumed in IDLE/WAIT_TX without a response; leds unchanged.
- 'L','2' then no byte for TIMEOUT_CYCLES (override to 100) -> FSM back in IDLE at cycle 100; no tx_start; leds unchanged; then a full valid frame for LED 2 works.
- Valid frame ending with tx_busy held high for 50 cycles -> tx_start stays 0 until tx_busy falls, then pulses once with 8'h4B.
- rx_err coinciding with rx_valid of the value byte -> NAK 8'h45; leds unchanged; reset pulsed low mid-frame -> leds=0 and state IDLE asynchronously.
- With USART_CMD_ERRCNT_EN: two bad frames, then 'C' -> tx_data=8'h02 sent; a following 'C' returns 8'h00.
